// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution engine output path.
// Holds the frame geometry, result widths and the buffered entry type.
package conv_pkg;

    localparam int CONV_X_LEN   = 112;
    localparam int CONV_F_LEN   = 49;
    localparam int CONV_POINTS  = CONV_X_LEN - CONV_F_LEN + 1;
    localparam int CONV_Y_WIDTH = 26;
    localparam int CONV_Q_WIDTH = 16;

    // One buffered requantized sample plus its end-of-frame marker.
    typedef struct packed {
        logic                           last;
        logic signed [CONV_Q_WIDTH-1:0] data;
    } y_entry_t;

endpackage

// File: rtl/y_requant_buf_if.sv
// Stream bundle for y_requant_buf: input result stream and framed output stream.
// master: environment side (drives in_*, out_ready); slave: the block itself.
interface y_requant_buf_if #(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 16
);
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/y_requant_buf_sync_fifo.sv
// sync_fifo: small synchronous FIFO with registered occupancy.
// Ports: clk, reset (sync, active-high), wr_en/wr_data, rd_en/rd_data, full, empty.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr, rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rptr_q];

    always_comb begin
        wr      = wr_en && !full;
        rd      = rd_en && !empty;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr) begin
            mem_d[wptr_q] = wr_data;
            // DEPTH is a power of two, so pointers wrap naturally.
            wptr_d = wptr_q + 1'b1;
        end
        if (rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/y_requant_buf.sv
// y_requant_buf: requantizes signed conv results to OUT_WIDTH (round-half-up,
// saturating), buffers them with an end-of-frame tag every CONV_POINTS outputs.
// Ports: clk, reset (sync, active-high), bus (y_requant_buf_if.slave), sat_flag (sticky).
// Optional: define REQUANT_RELU_EN to force negative results to 0 after saturation.
module y_requant_buf
    import conv_pkg::*;
#(
    parameter int IN_WIDTH    = CONV_Y_WIDTH,
    parameter int OUT_WIDTH   = CONV_Q_WIDTH,
    parameter int SHIFT       = 8,
    parameter int DEPTH       = 4,
    parameter int CONV_POINTS = conv_pkg::CONV_POINTS
) (
    input  logic             clk,
    input  logic             reset,
    y_requant_buf_if.slave   bus,
    output logic             sat_flag
);
    localparam int FCW = $clog2(CONV_POINTS);
    localparam int XW  = IN_WIDTH + 1;

    localparam logic signed [XW-1:0] RND   = XW'(1) <<< (SHIFT - 1);
    localparam logic signed [XW-1:0] Q_MAX = XW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic signed [XW-1:0] Q_MIN = -Q_MAX - XW'(1);
    localparam logic [FCW-1:0]       F_LAST = FCW'(CONV_POINTS - 1);

    logic signed [XW-1:0]        t_ext;
    logic signed [XW-1:0]        rq;
    logic                        sat_hi, sat_lo;
    logic signed [OUT_WIDTH-1:0] q_sat;
    logic signed [OUT_WIDTH-1:0] q_out;
    logic                        push, pop;
    logic                        full, empty;
    logic [FCW-1:0]              fcnt_q, fcnt_d;
    logic                        sat_q, sat_d;
    y_entry_t                    wr_entry;
    y_entry_t                    rd_entry;

    // Widen by one bit so adding the rounding constant cannot overflow.
    always_comb begin
        t_ext  = $signed({bus.in_data[IN_WIDTH-1], bus.in_data}) + RND;
        rq     = t_ext >>> SHIFT;
        sat_hi = (rq > Q_MAX);
        sat_lo = (rq < Q_MIN);
        if (sat_hi) begin
            q_sat = Q_MAX[OUT_WIDTH-1:0];
        end else if (sat_lo) begin
            q_sat = Q_MIN[OUT_WIDTH-1:0];
        end else begin
            q_sat = rq[OUT_WIDTH-1:0];
        end
`ifdef REQUANT_RELU_EN
        q_out = q_sat[OUT_WIDTH-1] ? '0 : q_sat;
`else
        q_out = q_sat;
`endif
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && !full;
    assign pop           = !empty && bus.out_ready;

    always_comb begin
        wr_entry.last = (fcnt_q == F_LAST);
        wr_entry.data = q_out;
        fcnt_d        = fcnt_q;
        // Saturation only counts for samples that actually enter the buffer.
        sat_d         = sat_q | (push & (sat_hi | sat_lo));
        if (push) begin
            fcnt_d = (fcnt_q == F_LAST) ? '0 : fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            sat_q  <= sat_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(y_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    assign bus.out_data = rd_entry.data;
    assign bus.out_last = rd_entry.last;
    assign sat_flag     = sat_q;
endmodule
